// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache refill controller
package cache_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int ADDR_WIDTH_DEF   = 32;
    localparam int WORD_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        FILL   = 2'd2,
        WR_REQ = 2'd3
    } refill_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - load-miss refill and write-through controller, no-write-allocate
// Optional hit/miss counters are built when CACHE_REFILL_PERF_CNT_EN is defined.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic                  lookup_we,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic [DATA_WIDTH-1:0] lookup_wdata,
    input  logic                  cache_hit,
    output logic                  stall,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  cache_overwrite,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_REFILL_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    refill_state_t         r_state;
    logic                  r_fill_en;
    logic [ADDR_WIDTH-1:0] r_fill_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic                  r_overwrite;
    logic                  r_store_hit;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_idle;
    logic                  w_load_hit;
    logic                  w_load_miss;
    logic                  w_store;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_idle      = (r_state == IDLE);
    assign w_load_hit  = w_idle && lookup_valid && !lookup_we && cache_hit;
    assign w_load_miss = w_idle && lookup_valid && !lookup_we && !cache_hit;
    assign w_store     = w_idle && lookup_valid && lookup_we;
    assign w_word_addr = {lookup_addr[ADDR_WIDTH-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};

    // In IDLE the stall must reach the pipeline in the same cycle as the lookup.
    assign stall = !rst && (!w_idle || w_load_miss || w_store);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fill_en   <= 1'b0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
            r_overwrite <= 1'b0;
            r_store_hit <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fill_en   <= 1'b0;
                    r_overwrite <= 1'b0;
                    if (w_load_miss) begin
                        r_fill_addr <= lookup_addr;
                        r_mem_addr  <= w_word_addr;
                        r_mem_we    <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_state     <= RD_REQ;
                    end else if (w_store) begin
                        r_fill_addr <= lookup_addr;
                        r_fill_data <= lookup_wdata;
                        r_store_hit <= cache_hit;
                        r_mem_addr  <= w_word_addr;
                        r_mem_wdata <= lookup_wdata;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_state     <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_ack) begin
                        r_fill_data <= mem_rdata;
                        r_fill_en   <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_fill_en <= 1'b0;
                    r_state   <= IDLE;
                end
                WR_REQ: begin
                    if (mem_ack) begin
                        r_overwrite <= r_store_hit;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fill_en         = r_fill_en;
    assign fill_addr       = r_fill_addr;
    assign fill_data       = r_fill_data;
    assign cache_overwrite = r_overwrite;
    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;

`ifdef CACHE_REFILL_PERF_CNT_EN
    sat_counter #(.WIDTH(32)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_load_hit),
        .o_count (hit_count)
    );

    sat_counter #(.WIDTH(32)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_load_miss),
        .o_count (miss_count)
    );
`else
    logic w_unused;
    assign w_unused = w_load_hit;
`endif

endmodule
